spiflash_writer: RTL
====================

Name: spiflash_writer

Overview:
- SPI-mode-0 flash programming master; the write-side counterpart of the flash block reader in iosys.
- Executes one of two operations: Page Program (02h) of 1..256 streamed bytes, or 4 KB Sector Erase (20h).
- Each operation is preceded by Write Enable (06h) and followed by Read Status (05h) polling until WIP clears.
- Sits beside the flash reader on the shared flash pins; the top level muxes ncs/mosi/sck by busy.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- CS_GAP, 4, minimum clk cycles ncs is held high between commands.
- POLL_MAX, 24'd8000000, maximum status reads before timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ncs  out  1  flash chip select, active low
- miso  in  1  flash serial out
- mosi  out  1  flash serial in
- sck  out  1  SPI clock, idle low
- start  in  1  one-cycle pulse that launches an operation; sampled only when busy=0
- op  in  1  0 = page program, 1 = sector erase; sampled with start
- addr  in  24  flash byte address; sampled with start
- len  in  9  program byte count, 1..256; ignored for erase
- din  in  8  program data byte
- din_valid  in  1  din holds a valid byte
- din_ready  out  1  one-cycle pulse; din is consumed in this cycle when din_valid=1
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at the end of every operation, including rejected ones
- err  out  2  status valid with done: 0 = ok, 1 = bad arguments, 2 = poll timeout

Behaviour:
- Reset values: ncs=1, sck=0, mosi=0, busy=0, din_ready=0, done=0, err=0. The FSM returns to IDLE.
- Reset mid-operation: ncs rises on the next edge. The flash then aborts the partial program; no recovery is attempted.
- Byte engine:
  - Shifts MSB first and samples miso on the rising sck edge.
  - mosi changes CLK_DIV cycles before each rising edge.
  - One byte takes 16*CLK_DIV cycles.
  - rx byte and ready are valid the cycle after the last falling edge.
- Argument check at start:
  - Bad when op=0 and len=0, len>256, or addr[7:0]+len>256 (crosses a page).
  - On a bad request: busy stays 0, and done=1 with err=1 one cycle after start. Nothing appears on the bus.
- FSM states:
  - IDLE: wait for start.
  - WREN: ncs low, send 06h.
  - GAP1: ncs high for CS_GAP cycles.
  - CMD: ncs low, send opcode, then addr[23:16], addr[15:8], addr[7:0].
  - DATA (op=0 only): for each byte, pulse din_ready while the engine is idle.
    - If din_valid=0, hold din_ready high each cycle until a byte is accepted.
    - sck stays low and ncs stays low during the stall.
    - Count len bytes.
  - GAP2: ncs high for CS_GAP cycles.
  - POLL: ncs low, send 05h, then clock dummy bytes while keeping ncs low.
    - After each received status byte: if bit0==0, go to DONE.
    - Otherwise increment the poll count. Reaching POLL_MAX gives err=2.
  - DONE: ncs=1, done=1 for one cycle, busy=0, back to IDLE.
- busy rises the cycle after an accepted start. It falls in the same cycle done pulses.
- start while busy=1 is ignored.
- Counters: the data count is 9 bits, compared to len; the poll count is 24 bits, saturating.

Decomposition:
- Shared package holds:
  - Opcode constants: CMD_WREN=06h, CMD_PP=02h, CMD_SE=20h, CMD_RDSR=05h.
  - Error code constants.
  - FSM state enum.
- One sub-module, spi_byte_engine: mode-0 shifter with start/ready, tx byte in, rx byte out, parameterised by CLK_DIV.
- The FSM, argument check and counters live in spiflash_writer.

Test Plan:
- Program, addr=24'h100010, len=4, data A5 5A 00 FF, model returns WIP=1 twice then 0
  -> bus shows 06h | gap | 02h 10h 00h 10h A5 5A 00 FF | gap | 05h and three status bytes.
  -> done=1, err=0, four din_ready pulses.
- Erase, addr=24'h003000, model WIP=1 for 5 reads -> 06h | 20h 00h 30h 00h | 05h and six status bytes; done, err=0.
- Argument errors -> done one cycle after start, err=1, ncs never low:
  - addr[7:0]=8'hF0, len=17.
  - len=0.
  - len=257.
- Stream stall: din_valid low for 50 cycles before byte 2 -> sck is flat and ncs stays low during the stall; the final byte sequence is intact.
- Timeout: POLL_MAX=3 and model WIP stuck at 1 -> exactly 3 status reads, then done with err=2 and ncs=1.
- Reset asserted during the 2nd data byte -> ncs=1, sck=0 and busy=0 on the next edge; no done pulse; a new start then works normally.

Source files
------------

// File: rtl/spiflash_writer_pkg.sv
// Shared constants and FSM encoding for the SPI flash programming master.
package spiflash_writer_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam logic [7:0] SR_WIP   = 8'h01;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ARGS    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_CMD,
        ST_DATA,
        ST_GAP2,
        ST_POLL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spiflash_writer_spi_byte_engine.sv
// Mode-0 SPI byte shifter: MSB first, miso captured on each rising sck edge.
// A byte occupies 16*CLK_DIV cycles; ready pulses once sck has returned low.
module spi_byte_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       busy,
    output logic       ready,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        active_q, active_d;
    logic        sck_q, sck_d;
    logic        ready_q, ready_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        ready_d  = 1'b0;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                tx_sh_d  = tx;
                div_d    = '0;
                bit_d    = '0;
                sck_d    = 1'b0;
            end
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!sck_q) begin
                sck_d   = 1'b1;
                rx_sh_d = {rx_sh_q[6:0], miso};
            end else begin
                // Falling edge: present the next bit; the final shift leaves mosi at 0.
                sck_d   = 1'b0;
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
                if (bit_q == 3'd7) begin
                    active_d = 1'b0;
                    ready_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            ready_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            ready_q  <= ready_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh_q <= rx_sh_d;
    end

    assign rx    = rx_sh_q;
    assign busy  = active_q;
    assign ready = ready_q;
    assign sck   = sck_q;
    assign mosi  = tx_sh_q[7];

endmodule

// File: rtl/spiflash_writer.sv
// SPI flash programming master: WREN, then page program or sector erase,
// then status polling until the write-in-progress bit clears.
module spiflash_writer
    import spiflash_writer_pkg::*;
#(
    parameter int          CLK_DIV  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [23:0] POLL_MAX = 24'd8000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ncs,
    input  logic        miso,
    output logic        mosi,
    output logic        sck,
    input  logic        start,
    input  logic        op,
    input  logic [23:0] addr,
    input  logic [8:0]  len,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    state_e      state_q, state_d;
    logic        ncs_q, ncs_d;
    logic [1:0]  err_q, err_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [23:0] poll_q, poll_d;
    logic [15:0] gap_q, gap_d;
    logic        op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;

    logic        eng_start, eng_busy, eng_ready, wip;
    logic [7:0]  eng_tx, eng_rx;
    logic        bad_args;

    spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .tx    (eng_tx),
        .rx    (eng_rx),
        .busy  (eng_busy),
        .ready (eng_ready),
        .sck   (sck),
        .mosi  (mosi),
        .miso  (miso)
    );

    // A program must stay inside one 256-byte page.
    assign bad_args = !op && (len == 9'd0 || len > 9'd256 ||
                              ({2'b00, addr[7:0]} + {1'b0, len}) > 10'd256);
    assign wip      = |(eng_rx & SR_WIP);

    always_comb begin
        state_d   = state_q;
        ncs_d     = ncs_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        op_d      = op_q;
        addr_d    = addr_q;
        len_d     = len_q;
        eng_start = 1'b0;
        eng_tx    = 8'h00;
        din_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ncs_d = 1'b1;
                if (start) begin
                    op_d   = op;
                    addr_d = addr;
                    len_d  = len;
                    if (bad_args) begin
                        err_d   = ERR_ARGS;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        ncs_d   = 1'b0;
                        state_d = ST_WREN;
                    end
                end
            end
            ST_WREN: begin
                if (eng_ready) begin
                    ncs_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP1;
                end else if (!eng_busy) begin
                    eng_start = 1'b1;
                    eng_tx    = CMD_WREN;
                end
            end
            ST_GAP1, ST_GAP2: begin
                if (gap_q == GAP_LAST) begin
                    ncs_d   = 1'b0;
                    idx_d   = '0;
                    poll_d  = '0;
                    state_d = (state_q == ST_GAP1) ? ST_CMD : ST_POLL;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_CMD: begin
                if (eng_ready) begin
                    if (idx_q == 2'd3) begin
                        cnt_d = '0;
                        gap_d = '0;
                        ncs_d = !op_q ? 1'b0 : 1'b1;
                        state_d = !op_q ? ST_DATA : ST_GAP2;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (!eng_busy) begin
                    eng_start = 1'b1;
                    case (idx_q)
                        2'd0:    eng_tx = op_q ? CMD_SE : CMD_PP;
                        2'd1:    eng_tx = addr_q[23:16];
                        2'd2:    eng_tx = addr_q[15:8];
                        default: eng_tx = addr_q[7:0];
                    endcase
                end
            end
            ST_DATA: begin
                // din_ready is held while the engine is idle, so a stall leaves sck flat.
                if (eng_ready && cnt_q == len_q) begin
                    ncs_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP2;
                end else if (!eng_busy && !eng_ready && cnt_q != len_q) begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        eng_start = 1'b1;
                        eng_tx    = din;
                        cnt_d     = cnt_q + 9'd1;
                    end
                end
            end
            ST_POLL: begin
                if (eng_ready) begin
                    if (idx_q == 2'd0) begin
                        idx_d = 2'd1;
                    end else if (!wip) begin
                        ncs_d   = 1'b1;
                        err_d   = ERR_OK;
                        state_d = ST_DONE;
                    end else begin
                        if (poll_q != '1) poll_d = poll_q + 24'd1;
                        if (poll_q >= POLL_MAX - 24'd1) begin
                            ncs_d   = 1'b1;
                            err_d   = ERR_TIMEOUT;
                            state_d = ST_DONE;
                        end
                    end
                end else if (!eng_busy) begin
                    eng_start = 1'b1;
                    eng_tx    = (idx_q == 2'd0) ? CMD_RDSR : 8'h00;
                end
            end
            ST_DONE: begin
                ncs_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ncs_q   <= 1'b1;
            err_q   <= ERR_OK;
            idx_q   <= '0;
            cnt_q   <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ncs_q   <= ncs_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        addr_q <= addr_d;
        len_q  <= len_d;
    end

    assign ncs  = ncs_q;
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);
    assign err  = done ? err_q : ERR_OK;

endmodule
